// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner: channel width,
// hex glyph table (active-low {g,f,e,d,c,b,a}) and the blank-digit pattern.
package disp_pkg;

    localparam int CH_W       = 32;
    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 15 is listed first: F E d C b A 9 8 7 6 5 4 3 2 1 0
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Groups the debug-source inputs and display outputs of disp_scan_ctrl;
// master drives channels/controls and observes the display, slave is the scanner.
interface disp_scan_ctrl_if
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int NUM_CH     = 4
);
    logic [NUM_CH*CH_W-1:0] ch_data;
    logic [2:0]             ch_sel;
    logic                   freeze;
    logic [NUM_DIGITS-1:0]  dp;
    logic [MAX_DIGITS-1:0]  seg;
    logic [MAX_DIGITS-1:0]  sel;
    logic                   frame;

    modport master (
        output ch_data, ch_sel, freeze, dp,
        input  seg, sel, frame
    );

    modport slave (
        input  ch_data, ch_sel, freeze, dp,
        output seg, sel, frame
    );

endinterface

// File: rtl/disp_scan_ctrl_seg_hex_dec.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module seg_hex_dec
    import disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_glyph(nib_i);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scanner showing a frame-coherent snapshot of one 32-bit debug channel.
// Optional build macro DISP_LZB_EN blanks leading-zero digits (digit 0 always shown).
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int NUM_CH      = 4,
    parameter int REFRESH_CYC = 50000
)(
    input  logic                   clk,
    input  logic                   resetIn,
    input  logic [NUM_CH*CH_W-1:0] ch_data_i,
    input  logic [2:0]             ch_sel_i,
    input  logic                   freeze_i,
    input  logic [NUM_DIGITS-1:0]  dp_i,
    output logic [7:0]             o_seg,
    output logic [7:0]             o_sel,
    output logic                   frame_o
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = $clog2(REFRESH_CYC);
    localparam int SNAP_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SNAP_W-1:0] snap_q, snap_d;
    logic [7:0]        seg_q, seg_d;
    logic [7:0]        sel_q, sel_d;
    logic              frame_q;

    logic              tick;
    logic              frame_start;
    logic [CH_W-1:0]   ch_word;
    logic [3:0]        nib;
    logic              dp_bit;
    logic              show_glyph;
    logic [6:0]        glyph;

    seg_hex_dec u_dec (
        .nib_i (nib),
        .seg_o (glyph)
    );

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        tick        = (cnt_q == CNT_LAST);
        frame_start = tick && (idx_q == IDX_LAST);
        cnt_d       = tick ? '0 : cnt_q + 1'b1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Out-of-range selects fall back to channel 0.
        ch_word = ch_data_i[CH_W-1:0];
        for (int k = 1; k < NUM_CH; k++) begin
            if (ch_sel_i == 3'(k)) begin
                ch_word = ch_data_i[k*CH_W +: CH_W];
            end
        end

        snap_d = snap_q;
        if (frame_start && !freeze_i) begin
            snap_d = ch_word[SNAP_W-1:0];
        end

        // Decode from next-state values so frame-0 outputs already show the new snapshot.
        nib    = '0;
        dp_bit = 1'b0;
        sel_d  = 8'hFF;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx_d == IDX_W'(d)) begin
                nib      = snap_d[4*d +: 4];
                dp_bit   = dp_i[d];
                sel_d[d] = 1'b0;
            end
        end

        show_glyph = 1'b1;
`ifdef DISP_LZB_EN
        begin : lzb
            logic [IDX_W-1:0] top_idx;
            top_idx = '0;
            for (int d = 1; d < NUM_DIGITS; d++) begin
                if (snap_d[4*d +: 4] != 4'h0) begin
                    top_idx = IDX_W'(d);
                end
            end
            show_glyph = (idx_d <= top_idx);
        end
`endif

        seg_d = {~dp_bit, show_glyph ? glyph : SEG_BLANK};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            cnt_q   <= '0;
            idx_q   <= IDX_LAST;
            snap_q  <= '0;
            seg_q   <= 8'hFF;
            sel_q   <= 8'hFF;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            frame_q <= frame_start;
            if (tick) begin
                seg_q <= seg_d;
                sel_q <= sel_d;
            end
        end
    end

    assign o_seg   = seg_q;
    assign o_sel   = sel_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: an 8-digit/4-channel instance checked per digit update,
// plus a 4-digit/3-channel instance checked for channel fallback, frame period and unused anodes.
module tb_disp_scan_ctrl;
    import disp_pkg::*;

    localparam int RC = 4;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] seg;
        logic       frame;
    } exp_t;

    logic clk = 1'b0;
    logic resetIn;
    always #5 clk = ~clk;

    disp_scan_ctrl_if #(.NUM_DIGITS(8), .NUM_CH(4)) bus ();

    disp_scan_ctrl #(.NUM_DIGITS(8), .NUM_CH(4), .REFRESH_CYC(RC)) dut (
        .clk       (clk),
        .resetIn   (resetIn),
        .ch_data_i (bus.ch_data),
        .ch_sel_i  (bus.ch_sel),
        .freeze_i  (bus.freeze),
        .dp_i      (bus.dp),
        .o_seg     (bus.seg),
        .o_sel     (bus.sel),
        .frame_o   (bus.frame)
    );

    logic [95:0] ch_data_b;
    logic [7:0]  seg_b, sel_b;
    logic        frame_b;

    disp_scan_ctrl #(.NUM_DIGITS(4), .NUM_CH(3), .REFRESH_CYC(RC)) dut_b (
        .clk       (clk),
        .resetIn   (resetIn),
        .ch_data_i (ch_data_b),
        .ch_sel_i  (3'd3),
        .freeze_i  (1'b0),
        .dp_i      (4'b0000),
        .o_seg     (seg_b),
        .o_sel     (sel_b),
        .frame_o   (frame_b)
    );

    logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg(input logic [31:0] word, input int d, input logic [7:0] dp);
        logic [6:0] g;
        int         top;
        g   = glyph_tbl[word[4*d +: 4]];
        top = 0;
        for (int i = 0; i < 8; i++) if (word[4*i +: 4] != 4'h0) top = i;
`ifdef DISP_LZB_EN
        if (d > top) g = 7'h7F;
`endif
        return {~dp[d], g};
    endfunction

    task automatic push_frame(input logic [31:0] word, input logic [7:0] dp);
        exp_t e;
        for (int d = 0; d < 8; d++) begin
            e.sel   = ~(8'h01 << d);
            e.seg   = exp_seg(word, d, dp);
            e.frame = (d == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_sel(input logic [7:0] s);
        int i;
        for (i = 0; i < 100 && bus.sel !== s; i++) @(negedge clk);
        if (bus.sel !== s) check("wait_sel_timeout", bus.sel, s);
    endtask

    // Monitor A: every digit update is compared against the scoreboard; frame spacing checked.
    initial begin
        logic [7:0] prev_sel;
        int cyc, last_f;
        exp_t e;
        prev_sel = 8'hFF;
        cyc = 0;
        last_f = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (resetIn) begin
                prev_sel = 8'hFF;
                last_f   = -1;
            end else begin
                if (bus.sel !== prev_sel) begin
                    prev_sel = bus.sel;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("sel", bus.sel, e.sel);
                        check("seg", bus.seg, e.seg);
                        check("frame", bus.frame, e.frame);
                    end
                end
                if (bus.frame) begin
                    if (last_f >= 0) check("frame_period", cyc - last_f, 32);
                    last_f = cyc;
                end
            end
        end
    end

    // Monitor B: sel=3 with three channels must show channel 0 (32'h7654).
    initial begin
        logic [7:0] prev_sel;
        int cyc, last_f;
        prev_sel = 8'hFF;
        cyc = 0;
        last_f = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (resetIn) begin
                prev_sel = 8'hFF;
                last_f   = -1;
            end else begin
                if (sel_b !== prev_sel) begin
                    prev_sel = sel_b;
                    check("b_sel_hi", sel_b[7:4], 4'hF);
                    if (sel_b == 8'hF7) check("b_dig3", seg_b, 8'hF8);
                end
                if (frame_b) begin
                    check("b_dig0_sel", sel_b, 8'hFE);
                    check("b_dig0_seg", seg_b, 8'h99);
                    if (last_f >= 0) check("b_frame_period", cyc - last_f, 16);
                    last_f = cyc;
                end
            end
        end
    end

    initial begin
        int n;
        resetIn     = 1'b1;
        bus.ch_data = {32'h0, 32'h0, 32'h0, 32'h1234_ABCD};
        bus.ch_sel  = 3'd0;
        bus.freeze  = 1'b0;
        bus.dp      = 8'h00;
        ch_data_b   = {32'hDEAD_BEEF, 32'hCAFE_0000, 32'h0000_7654};
        repeat (3) @(negedge clk);
        check("rst_seg", bus.seg, 8'hFF);
        check("rst_sel", bus.sel, 8'hFF);
        check("rst_frame", bus.frame, 1'b0);
        resetIn = 1'b0;

        // Basic scan of 1234_ABCD, then decimal points on digits 0 and 2.
        push_frame(32'h1234_ABCD, 8'h00);
        drain();
        bus.dp = 8'h05;
        push_frame(32'h1234_ABCD, 8'h05);
        drain();
        bus.dp = 8'h00;

        // Mid-frame channel switch must not tear the current frame.
        push_frame(32'h1234_ABCD, 8'h00);
        wait_sel(8'hF7);
        bus.ch_sel = 3'd1;
        drain();
        push_frame(32'h0, 8'h00);
        drain();

        // Freeze holds the snapshot across two frames while ch0 changes.
        bus.ch_sel = 3'd0;
        push_frame(32'h1234_ABCD, 8'h00);
        drain();
        bus.freeze = 1'b1;
        bus.ch_data[31:0] = 32'hFFFF_FFFF;
        push_frame(32'h1234_ABCD, 8'h00);
        drain();
        push_frame(32'h1234_ABCD, 8'h00);
        drain();
        bus.freeze = 1'b0;
        push_frame(32'hFFFF_FFFF, 8'h00);
        drain();

        // Leading-zero patterns.
        bus.ch_data[31:0] = 32'h0000_00A5;
        push_frame(32'h0000_00A5, 8'h00);
        drain();
        bus.ch_data[31:0] = 32'h0;
        push_frame(32'h0, 8'h00);
        drain();

        // Asynchronous reset during digit 5, then clean restart.
        bus.ch_data[31:0] = 32'h1234_ABCD;
        push_frame(32'h1234_ABCD, 8'h00);
        wait_sel(8'hDF);
        exp_q.delete();
        #2 resetIn = 1'b1;
        #1;
        check("async_rst_seg", bus.seg, 8'hFF);
        check("async_rst_sel", bus.sel, 8'hFF);
        check("async_rst_frame", bus.frame, 1'b0);
        repeat (2) @(negedge clk);
        resetIn = 1'b0;
        push_frame(32'h1234_ABCD, 8'h00);
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.frame) break;
        end
        check("rst_first_frame_cyc", n, 4);
        drain();
        push_frame(32'h1234_ABCD, 8'h00);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of scanned digits (1..8).
REQ-002 SHALL have parameter NUM_CH, default 4, number of 32-bit debug source channels (1..8).
REQ-003 SHALL have parameter REFRESH_CYC, default 50000, clk cycles per digit dwell (>=2).
REQ-004 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-005 SHALL have port resetIn, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port ch_data_i, input, NUM_CH*32, packed channels; channel k is bits [32k+31:32k].
REQ-007 SHALL have port ch_sel_i, input, 3, channel select.
REQ-008 SHALL have port freeze_i, input, 1, holds the current snapshot while high.
REQ-009 SHALL have port dp_i, input, NUM_DIGITS, decimal point per digit (active-high request).
REQ-010 SHALL have port o_seg, output, 8, registered active-low segments {dp,g,f,e,d,c,b,a}.
REQ-011 SHALL have port o_sel, output, 8, registered active-low one-hot digit anode select.
REQ-012 SHALL have port frame_o, output, 1, one-cycle pulse at each frame start.

Function
REQ-013 SHALL run a dwell counter 0..REFRESH_CYC-1; the wrap cycle is a "tick".
REQ-014 SHALL, on tick, advance digit index 0..NUM_DIGITS-1, wrapping to 0.
REQ-015 SHALL treat a tick with index wrapping to 0 (and the first tick after reset) as a frame start.
REQ-016 SHALL, at frame start with freeze_i low, load snapshot with the low 4*NUM_DIGITS bits of the selected channel; with freeze_i high, keep snapshot.
REQ-017 SHALL treat ch_sel_i >= NUM_CH as channel 0.
REQ-018 SHALL apply ch_sel_i and ch_data_i changes only at frame start (no tearing within a frame).
REQ-019 SHALL, one cycle after each tick, update o_sel to drive bit[index] low and all other bits high, and update o_seg to the hex decode of snapshot nibble[index].
REQ-020 SHALL drive o_sel bits >= NUM_DIGITS high at all times.
REQ-021 SHALL decode 0-F to standard hex glyphs (b,d lowercase); o_seg[7] low iff dp_i[index] high, dp_i sampled on the same edge.
REQ-022 SHALL pulse frame_o high for exactly the cycle in which the frame-0 outputs update.
REQ-023 SHALL, with NUM_DIGITS=1, tick-refresh digit 0 and assert frame_o on every tick.

Reset
REQ-024 SHALL, while resetIn high, hold counter=0, index=NUM_DIGITS-1, snapshot=0, o_seg=8'hFF, o_sel=8'hFF, frame_o=0.
REQ-025 SHALL, on release of resetIn mid-frame, restart scanning cleanly; first output update and first frame_o follow the first tick (REFRESH_CYC cycles after release).

Configuration
REQ-026 SHALL support macro DISP_LZB_EN: when defined, digits above the most-significant nonzero snapshot nibble show blank segments (7'h7F, dp still honoured), digit 0 always shown; when undefined, all digits show their glyph.

Structure
REQ-027 SHALL place the 16-entry hex-to-segment table and blank constant in shared package disp_pkg.
REQ-028 SHALL use one sub-module seg_hex_dec (4-bit nibble in, 7-bit active-low segments out, combinational).

Verification
REQ-029 SHALL test: REFRESH_CYC=4, NUM_DIGITS=8, ch0=32'h1234_ABCD, sel=0 -> digit0 o_sel=8'hFE o_seg=8'hA1 ('d'), digit7 o_sel=8'h7F o_seg=8'hF9 ('1'); frame_o every 32 cycles.
REQ-030 SHALL test: change sel 0->1 (ch1=32'h0) mid-frame -> digits keep ch0 values until the next frame_o, then all show 8'hC0 ('0').
REQ-031 SHALL test: freeze_i=1 over two frames while ch0 changes to 32'hFFFF_FFFF -> display stays 1234_ABCD; after freeze_i=0 next frame shows 8'h8E ('F') on all digits.
REQ-032 SHALL test: DISP_LZB_EN defined, ch0=32'h0000_00A5 -> digits 2..7 o_seg=8'hFF, digit1 8'h88, digit0 8'h92; ch0=0 -> only digit0 shows 8'hC0.
REQ-033 SHALL test: resetIn pulsed during digit 5 -> o_seg=o_sel=8'hFF immediately (async); after release, first update after 4 cycles on digit0 with frame_o.
REQ-034 SHALL test: NUM_CH=3, sel=3 -> channel 0 displayed; NUM_DIGITS=4 -> o_sel[7:4] always 1, frame_o every 16 cycles.
